// File: rtl/vis_frame_ctrl.sv
// vis_frame_ctrl
// Integration-period and output-bank controller for the correlator back end.
// A block counter frames groups of COUNT-sample blocks and qualifies the
// accumulator with first/last flags. A separate write side steers accumulator
// words into a two-bank visibility SRAM, hands full banks to the reader and
// drops whole frames when no bank is free.
//
// Ports
//   vis_clock      correlator clock
//   reset_n        synchronous, active-low reset
//   enable_i       level: run integrations
//   nblk_i         blocks per frame, latched on IDLE->RUN (0 behaves as 1)
//   blk_done_i     pulse: one block finished
//   vis_first_o    current block is the first of its frame
//   vis_last_o     current block is the last of its frame
//   vis_start_o    1-cycle pulse on entering RUN from IDLE
//   vis_frame_o    1-cycle pulse after the block that ends a frame
//   acc_valid_i    accumulator output word valid
//   wr_en_o        SRAM write strobe (registered)
//   wr_bank_o      SRAM bank select (registered)
//   wr_addr_o      SRAM word address (registered)
//   rd_ready_o     rd_bank_o holds a complete frame
//   rd_bank_o      bank for the reader
//   rd_release_i   pulse: reader finished rd_bank_o
//   overflow_o     sticky: at least one frame dropped
//   frame_cnt_o    (stats build) completed frames
//   drop_cnt_o     (stats build) dropped frames, saturating
//
// Build option: define VIS_FRAME_CTRL_STATS_EN to add frame_cnt_o/drop_cnt_o.
// OBITS must satisfy 2**OBITS >= CORES*TRATE.
module vis_frame_ctrl #(
    parameter int CORES = 18,
    parameter int TRATE = 30,
    parameter int OBITS = 10,
    parameter int KBITS = 16
) (
    input  logic             vis_clock,
    input  logic             reset_n,
    input  logic             enable_i,
    input  logic [KBITS-1:0] nblk_i,
    input  logic             blk_done_i,
    output logic             vis_first_o,
    output logic             vis_last_o,
    output logic             vis_start_o,
    output logic             vis_frame_o,
    input  logic             acc_valid_i,
    output logic             wr_en_o,
    output logic             wr_bank_o,
    output logic [OBITS-1:0] wr_addr_o,
    output logic             rd_ready_o,
    output logic             rd_bank_o,
    input  logic             rd_release_i,
`ifdef VIS_FRAME_CTRL_STATS_EN
    output logic [31:0]      frame_cnt_o,
    output logic [15:0]      drop_cnt_o,
`endif
    output logic             overflow_o
);

    localparam int TOTAL = CORES * TRATE;
    localparam logic [OBITS-1:0] LAST_ADDR = OBITS'(TOTAL - 1);

    // state | meaning
    // IDLE  | not integrating; blk_done_i ignored
    // RUN   | integrating, enable_i high
    // STOP  | enable_i dropped; finishing the current frame
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [KBITS-1:0] nblk, nblk_nxt;
    logic [KBITS-1:0] blk_cnt, blk_cnt_nxt;
    logic             start_nxt, frame_nxt;
    logic             running, blk_end;

    assign running = (state != ST_IDLE);
    assign blk_end = (blk_cnt == nblk - KBITS'(1));

    always_ff @(posedge vis_clock) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            nblk        <= KBITS'(1);
            blk_cnt     <= '0;
            vis_start_o <= 1'b0;
            vis_frame_o <= 1'b0;
        end else begin
            state       <= state_nxt;
            nblk        <= nblk_nxt;
            blk_cnt     <= blk_cnt_nxt;
            vis_start_o <= start_nxt;
            vis_frame_o <= frame_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        nblk_nxt    = nblk;
        blk_cnt_nxt = blk_cnt;
        start_nxt   = 1'b0;
        frame_nxt   = 1'b0;

        if (running && blk_done_i) begin
            frame_nxt   = blk_end;
            blk_cnt_nxt = blk_end ? '0 : blk_cnt + KBITS'(1);
        end

        case (state)
            ST_IDLE: begin
                if (enable_i) begin
                    state_nxt   = ST_RUN;
                    nblk_nxt    = (nblk_i == '0) ? KBITS'(1) : nblk_i;
                    blk_cnt_nxt = '0;
                    start_nxt   = 1'b1;
                end
            end
            ST_RUN: begin
                // Enable falling on the very block that closes a frame has
                // nothing left to finish, so go straight to IDLE.
                if (!enable_i)
                    state_nxt = (blk_done_i && blk_end) ? ST_IDLE : ST_STOP;
            end
            ST_STOP: begin
                if (enable_i)
                    state_nxt = ST_RUN;
                else if (blk_done_i && blk_end)
                    state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign vis_first_o = running && (blk_cnt == '0);
    assign vis_last_o  = running && blk_end;

    logic [OBITS-1:0] wr_ptr;
    logic             wbank, drop, rd_bank, overflow;
    logic [1:0]       full, full_seen, rel_mask, set_mask;
    logic             rel_ok, first_word, last_word, drop_eff;

    assign rel_ok     = rd_release_i && full[rd_bank];
    assign rel_mask   = rel_ok ? (rd_bank ? 2'b10 : 2'b01) : 2'b00;
    // A release in the same cycle is applied before the drop check sees it.
    assign full_seen  = full & ~rel_mask;
    assign first_word = acc_valid_i && (wr_ptr == '0);
    assign last_word  = acc_valid_i && (wr_ptr == LAST_ADDR);
    assign drop_eff   = (wr_ptr == '0) ? full_seen[wbank] : drop;
    assign set_mask   = (last_word && !drop_eff) ? (wbank ? 2'b10 : 2'b01) : 2'b00;

    always_ff @(posedge vis_clock) begin
        if (!reset_n) begin
            wr_en_o   <= 1'b0;
            wr_bank_o <= 1'b0;
            wr_addr_o <= '0;
            wr_ptr    <= '0;
            wbank     <= 1'b0;
            drop      <= 1'b0;
            full      <= 2'b00;
            rd_bank   <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            wr_en_o   <= acc_valid_i && !drop_eff;
            wr_bank_o <= wbank;
            wr_addr_o <= wr_ptr;
            full      <= full_seen | set_mask;
            if (rel_ok)
                rd_bank <= ~rd_bank;
            if (first_word && drop_eff)
                overflow <= 1'b1;
            if (acc_valid_i) begin
                drop <= drop_eff;
                if (last_word) begin
                    wr_ptr <= '0;
                    if (!drop_eff)
                        wbank <= ~wbank;
                end else begin
                    wr_ptr <= wr_ptr + OBITS'(1);
                end
            end
        end
    end

    assign rd_ready_o = full[rd_bank];
    assign rd_bank_o  = rd_bank;
    assign overflow_o = overflow;

`ifdef VIS_FRAME_CTRL_STATS_EN
    always_ff @(posedge vis_clock) begin
        if (!reset_n) begin
            frame_cnt_o <= '0;
            drop_cnt_o  <= '0;
        end else begin
            if (vis_frame_o)
                frame_cnt_o <= frame_cnt_o + 32'd1;
            if (first_word && drop_eff && (drop_cnt_o != 16'hFFFF))
                drop_cnt_o <= drop_cnt_o + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vis_frame_ctrl.sv
module tb_vis_frame_ctrl;

    localparam int CORES = 18;
    localparam int TRATE = 30;
    localparam int TOTAL = CORES * TRATE;
    localparam int OBITS = 10;
    localparam int KBITS = 16;

    logic             vis_clock = 1'b0;
    logic             reset_n;
    logic             enable_i;
    logic [KBITS-1:0] nblk_i;
    logic             blk_done_i;
    logic             vis_first_o, vis_last_o, vis_start_o, vis_frame_o;
    logic             acc_valid_i;
    logic             wr_en_o, wr_bank_o;
    logic [OBITS-1:0] wr_addr_o;
    logic             rd_ready_o, rd_bank_o, rd_release_i, overflow_o;
`ifdef VIS_FRAME_CTRL_STATS_EN
    logic [31:0]      frame_cnt_o;
    logic [15:0]      drop_cnt_o;
`endif

    always #5 vis_clock = ~vis_clock;

    vis_frame_ctrl #(.CORES(CORES), .TRATE(TRATE), .OBITS(OBITS), .KBITS(KBITS)) dut (
        .vis_clock    (vis_clock),
        .reset_n      (reset_n),
        .enable_i     (enable_i),
        .nblk_i       (nblk_i),
        .blk_done_i   (blk_done_i),
        .vis_first_o  (vis_first_o),
        .vis_last_o   (vis_last_o),
        .vis_start_o  (vis_start_o),
        .vis_frame_o  (vis_frame_o),
        .acc_valid_i  (acc_valid_i),
        .wr_en_o      (wr_en_o),
        .wr_bank_o    (wr_bank_o),
        .wr_addr_o    (wr_addr_o),
        .rd_ready_o   (rd_ready_o),
        .rd_bank_o    (rd_bank_o),
        .rd_release_i (rd_release_i),
`ifdef VIS_FRAME_CTRL_STATS_EN
        .frame_cnt_o  (frame_cnt_o),
        .drop_cnt_o   (drop_cnt_o),
`endif
        .overflow_o   (overflow_o)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
        end
    endtask

    // Reference model: frame-level view of the block sequencer and a queue of
    // banks holding complete frames, oldest first.
    bit m_run, m_start, m_frame;
    int m_n, m_idx;
    int m_words;
    bit m_keep, m_wbank, m_rbank, m_ovf;
    bit m_wen, m_wbk;
    int m_waddr;
    bit ready_q[$];
    int m_frames, m_drops;
    int n_starts, n_frames_seen, n_drop_words;

    function automatic void model_reset();
        m_run = 0; m_start = 0; m_frame = 0; m_n = 1; m_idx = 0;
        m_words = 0; m_keep = 1; m_wbank = 0; m_rbank = 0; m_ovf = 0;
        m_wen = 0; m_wbk = 0; m_waddr = 0;
        ready_q.delete();
        m_frames = 0; m_drops = 0;
    endfunction

    function automatic bit bank_full(bit b);
        foreach (ready_q[i]) if (ready_q[i] == b) return 1;
        return 0;
    endfunction

    function automatic void model_step(bit en, int nblk, bit bd, bit av, bit rel);
        if (m_frame) m_frames++;
        m_start = 0;
        m_frame = 0;
        if (!m_run) begin
            if (en) begin
                m_run = 1; m_n = (nblk == 0) ? 1 : nblk; m_idx = 0; m_start = 1;
            end
        end else if (bd) begin
            if (m_idx == m_n - 1) begin
                m_frame = 1; m_idx = 0;
                if (!en) m_run = 0;
            end else begin
                m_idx++;
            end
        end

        if (rel && ready_q.size() > 0) begin
            void'(ready_q.pop_front());
            m_rbank = ~m_rbank;
        end

        m_wen = 0;
        if (av) begin
            if (m_words == 0) begin
                m_keep = !bank_full(m_wbank);
                if (!m_keep) begin
                    m_ovf = 1;
                    if (m_drops < 65535) m_drops++;
                end
            end
            m_wen = m_keep; m_wbk = m_wbank; m_waddr = m_words;
            m_words++;
            if (m_words == TOTAL) begin
                m_words = 0;
                if (m_keep) begin
                    ready_q.push_back(m_wbank);
                    m_wbank = ~m_wbank;
                end
            end
        end
    endfunction

    task automatic check_all();
        check_val("vis_first", 32'(vis_first_o), 32'(m_run && m_idx == 0));
        check_val("vis_last",  32'(vis_last_o),  32'(m_run && m_idx == m_n - 1));
        check_val("vis_start", 32'(vis_start_o), 32'(m_start));
        check_val("vis_frame", 32'(vis_frame_o), 32'(m_frame));
        check_val("wr_en",     32'(wr_en_o),     32'(m_wen));
        if (m_wen) begin
            check_val("wr_bank", 32'(wr_bank_o), 32'(m_wbk));
            check_val("wr_addr", 32'(wr_addr_o), 32'(m_waddr));
        end
        check_val("rd_ready",  32'(rd_ready_o),  32'(ready_q.size() > 0));
        check_val("rd_bank",   32'(rd_bank_o),   32'(m_rbank));
        check_val("overflow",  32'(overflow_o),  32'(m_ovf));
`ifdef VIS_FRAME_CTRL_STATS_EN
        check_val("frame_cnt", frame_cnt_o,      32'(m_frames));
        check_val("drop_cnt",  32'(drop_cnt_o),  32'(m_drops));
`endif
        if (m_start) n_starts++;
        if (m_frame) n_frames_seen++;
        if (!m_wen && m_words != 0 && !m_keep) n_drop_words++;
    endtask

    task automatic step(input bit en, input int nblk, input bit bd, input bit av, input bit rel);
        enable_i     = en;
        nblk_i       = KBITS'(nblk);
        blk_done_i   = bd;
        acc_valid_i  = av;
        rd_release_i = rel;
        model_step(en, nblk, bd, av, rel);
        @(negedge vis_clock);
        check_all();
    endtask

    task automatic do_reset();
        reset_n = 0;
        enable_i = 0; nblk_i = '0; blk_done_i = 0; acc_valid_i = 0; rd_release_i = 0;
        repeat (3) @(negedge vis_clock);
        model_reset();
        check_all();
        reset_n = 1;
    endtask

    // Random run: release_prob out of 1000 per cycle; aim_release also fires
    // a release on the last word of a frame whenever a bank is waiting.
    task automatic random_run(input int cycles, input int valid_pct, input int release_prob,
                              input bit aim_release);
        bit en, bd, av, rel;
        int nb;
        en = 1;
        nb = $urandom_range(0, 5);
        for (int c = 0; c < cycles; c++) begin
            if ($urandom_range(0, 99) == 0) en = ~en;
            if ($urandom_range(0, 49) == 0) nb = $urandom_range(0, 5);
            bd  = ($urandom_range(0, 5) == 0);
            av  = ($urandom_range(0, 99) < valid_pct);
            rel = ($urandom_range(0, 999) < release_prob);
            if (aim_release && av && m_words == TOTAL - 1 && ready_q.size() > 0 &&
                $urandom_range(0, 1) == 1)
                rel = 1;
            step(en, nb, bd, av, rel);
        end
    endtask

    initial begin
        n_starts = 0; n_frames_seen = 0; n_drop_words = 0;
        model_reset();
        do_reset();

        // Fixed cadence: nblk=4, block every 15 cycles, reader idle.
        for (int c = 0; c < 300; c++)
            step(1, 4, (c % 15) == 14, $urandom_range(0, 1), 0);
        check_val("start_once", 32'(n_starts), 32'd1);
        check_val("frames_300", 32'(n_frames_seen), 32'd5);

        // Fill both banks and drop at least one frame.
        random_run(2200, 95, 0, 0);
        check_val("dropped_seen", 32'(n_drop_words > 0), 32'd1);

        // Drain with occasional and frame-aligned releases.
        random_run(3000, 80, 4, 1);

        // Enable dropped mid-frame: nblk=4, blocks every 10 cycles.
        step(0, 0, 0, 0, 0);
        for (int c = 0; c < 25; c++) step(1, 4, (c % 10) == 9, 0, 0);
        for (int c = 0; c < 60; c++) step(0, 4, (c % 10) == 9, 0, 0);

        // Reset mid-frame, then continue randomly.
        random_run(300, 90, 5, 0);
        do_reset();
        random_run(1500, 85, 8, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
